// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// default MMIO base and the request fault decode used by the top level.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'hFFFF0000;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        RMW_RD,
        RMW_CAP,
        ST_WR,
        ERR
    } lsu_state_t;

    // Exactly one of load/store must be set, and funct3 must be legal for that kind.
    function automatic logic is_illegal(logic ld, logic st, logic [2:0] f3);
        logic legal;
        if (ld == st) begin
            legal = 1'b0;
        end else if (ld) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return !legal;
    endfunction

    function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] offset);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and store
// merge of a byte/halfword into an existing word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] st_old,
    input  logic [31:0] st_data,
    output logic [31:0] ld_result,
    output logic [31:0] st_merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = ld_word[{offset, 3'b000} +: 8];
        lane_h = ld_word[{offset[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    ld_result = {{24{lane_b[7]}}, lane_b};
            F3_H:    ld_result = {{16{lane_h[15]}}, lane_h};
            F3_BU:   ld_result = {24'h0, lane_b};
            F3_HU:   ld_result = {16'h0, lane_h};
            default: ld_result = ld_word;
        endcase

        st_merged = st_old;
        case (funct3)
            F3_B:    st_merged[{offset, 3'b000} +: 8] = st_data[7:0];
            F3_H:    st_merged[{offset[1], 4'b0000} +: 16] = st_data[15:0];
            default: st_merged = st_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: drives word-wide data-memory reads/writes, handles
// read latency, lane extraction and sub-word stores via read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = DEFAULT_IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        load_q, store_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merged_q;

    logic        accept, req_fault, ill_q, mis_q, mmio_q;
    logic [31:0] ld_result, st_merged, word_addr;

    assign accept    = req_valid && req_ready;
    assign req_fault = is_illegal(req_load, req_store, req_funct3) ||
                       is_misaligned(req_funct3, req_addr[1:0]);
    assign ill_q     = is_illegal(load_q, store_q, f3_q);
    assign mis_q     = is_misaligned(f3_q, addr_q[1:0]);
    assign mmio_q    = (addr_q >= IO_BASE);
    assign word_addr = {addr_q[31:2], 2'b00};

    // Outside RMW_CAP the old word is zero, which yields the MMIO lane-shifted store data.
    lsu_align u_align (
        .ld_word   (mem_rdata),
        .offset    (addr_q[1:0]),
        .funct3    (f3_q),
        .st_old    ((state_q == RMW_CAP) ? mem_rdata : 32'h0),
        .st_data   (wdata_q),
        .ld_result (ld_result),
        .st_merged (st_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                load_q  <= req_load;
                store_q <= req_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == RMW_CAP) begin
                merged_q <= st_merged;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'h0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = 32'h0;
        mem_wdata       = 32'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_fault) begin
                        state_d = ERR;
                    end else if (req_load) begin
                        state_d = LD_RD;
                    end else if (req_funct3 == F3_W || req_addr >= IO_BASE) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_RD: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                state_d  = LD_CAP;
            end
            LD_CAP: begin
                mem_read   = 1'b1;
                mem_addr   = word_addr;
                resp_valid = 1'b1;
                resp_rdata = ld_result;
                state_d    = IDLE;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                state_d  = RMW_CAP;
            end
            RMW_CAP: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                state_d  = ST_WR;
            end
            ST_WR: begin
                mem_write  = 1'b1;
                mem_addr   = word_addr;
                mem_wdata  = (mmio_q || f3_q == F3_W) ? st_merged : merged_q;
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            ERR: begin
                resp_valid      = 1'b1;
                resp_illegal    = ill_q;
                resp_misaligned = !ill_q && mis_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a request-level model predicts
// strobes and responses each cycle; directed vectors carry literal expectations.
module tb_load_store_unit;

    localparam logic [31:0] IO_BASE = 32'hFFFF0000;

    logic        clk, rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_illegal;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    load_store_unit #(.IO_BASE(IO_BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_load        (req_load),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: 64 words of RAM at 0x00..0xFF, one-cycle synchronous read.
    logic [31:0] ram [64];
    logic        poke_en;
    logic [31:0] poke_addr, poke_data;

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr[7:2]] <= poke_data;
        if (mem_read) mem_rdata <= (mem_addr < 32'h100) ? ram[mem_addr[7:2]] : 32'h0;
        if (mem_write && mem_addr < 32'h100) ram[mem_addr[7:2]] <= mem_wdata;
    end

    function automatic logic [31:0] ram_word(logic [31:0] a);
        return (a < 32'h100) ? ram[a[7:2]] : 32'h0;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference semantics of RV32I sub-word access, expressed on bytes.
    function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a[1:0]));
        h = 16'(w >> (a[1] ? 16 : 0));
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] old, logic [31:0] d, logic [31:0] a,
                                            logic [2:0] f3);
        logic [7:0] by [4];
        for (int i = 0; i < 4; i++) by[i] = old[8*i +: 8];
        case (f3)
            3'd0: by[a[1:0]] = d[7:0];
            3'd1: begin
                by[{a[1], 1'b0}] = d[7:0];
                by[{a[1], 1'b1}] = d[15:8];
            end
            default: for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
        endcase
        return {by[3], by[2], by[1], by[0]};
    endfunction

    // Literal expectations attached to the request being issued.
    logic [31:0] lit_rdata, lit_wdata;
    logic [1:0]  lit_flags;

    // Model state for the request in flight.
    logic        pending;
    int          since, kind;
    logic        m_ld, m_st, m_ill, m_mis;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_lit_rdata, m_lit_wdata;
    logic [1:0]  m_lit_flags;

    initial begin
        logic exp_rd, exp_wr, exp_rv;
        logic [31:0] exp_w;
        pending = 1'b0;
        since   = 0;
        kind    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
                chk("rst_ready", 32'(req_ready), 32'd1);
                chk("rst_mem_read", 32'(mem_read), 32'd0);
                chk("rst_mem_write", 32'(mem_write), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_resp_rdata", resp_rdata, 32'h0);
                chk("rst_flags", {30'h0, resp_illegal, resp_misaligned}, 32'h0);
            end else begin
                if (pending) begin
                    since++;
                    // kind: 0 fault, 1 load, 2 single-cycle store, 3 read-modify-write store
                    exp_rd = (kind == 1 || kind == 3) && since <= 2;
                    exp_wr = (kind == 2 && since == 1) || (kind == 3 && since == 3);
                    exp_rv = (since == ((kind == 1) ? 2 : (kind == 3) ? 3 : 1));
                    chk("busy_ready", 32'(req_ready), 32'd0);
                    chk("mem_read", 32'(mem_read), 32'(exp_rd));
                    chk("mem_write", 32'(mem_write), 32'(exp_wr));
                    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
                    if (exp_rd || exp_wr) chk("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
                    if (exp_wr) begin
                        exp_w = m_store((kind == 3) ? ram_word(m_addr) : 32'h0,
                                        m_wdata, m_addr, m_f3);
                        chk("mem_wdata", mem_wdata, exp_w);
                        chk("lit_wdata", mem_wdata, m_lit_wdata);
                    end
                    if (exp_rv) begin
                        chk("resp_rdata", resp_rdata,
                            (kind == 1) ? m_load(ram_word(m_addr), m_addr, m_f3) : 32'h0);
                        chk("lit_rdata", resp_rdata, m_lit_rdata);
                        chk("resp_flags", {30'h0, resp_illegal, resp_misaligned},
                            {30'h0, m_ill, m_mis});
                        chk("lit_flags", {30'h0, resp_illegal, resp_misaligned},
                            {30'h0, m_lit_flags});
                        pending = 1'b0;
                    end
                end else begin
                    chk("idle_ready", 32'(req_ready), 32'd1);
                    chk("idle_strobes", {30'h0, mem_read, mem_write}, 32'h0);
                    chk("idle_resp", 32'(resp_valid), 32'd0);
                end
                if (req_valid && req_ready) begin
                    m_ld    = req_load;
                    m_st    = req_store;
                    m_f3    = req_funct3;
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_lit_rdata = lit_rdata;
                    m_lit_wdata = lit_wdata;
                    m_lit_flags = lit_flags;
                    m_ill = (m_ld == m_st) ||
                            (m_ld && !(m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                            (m_st && !(m_f3 inside {3'd0, 3'd1, 3'd2}));
                    m_mis = !m_ill && (((m_f3 == 3'd1 || m_f3 == 3'd5) && m_addr[0]) ||
                                       (m_f3 == 3'd2 && m_addr[1:0] != 2'b00));
                    if (m_ill || m_mis) kind = 0;
                    else if (m_ld) kind = 1;
                    else if (m_f3 == 3'd2 || m_addr >= IO_BASE) kind = 2;
                    else kind = 3;
                    since   = 0;
                    pending = 1'b1;
                end
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] lr, input logic [31:0] lw, input logic [1:0] lf);
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        lit_rdata  = lr;
        lit_wdata  = lw;
        lit_flags  = lf;
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (!pending) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_load = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        lit_rdata = 32'h0;
        lit_wdata = 32'h0;
        lit_flags = 2'b00;
        poke_en = 1'b0;
        poke_addr = 32'h0;
        poke_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        poke(32'h10, 32'hDEADBEEF);
        poke(32'h20, 32'h11223344);
        poke(32'h30, 32'hCAFEF00D);
        rst = 1'b0;

        issue(1, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00); wait_done();
        poke(32'h10, 32'h80FF7F01);
        issue(1, 0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 32'h0, 2'b00); wait_done();
        issue(1, 0, 3'd4, 32'h13, 32'h0, 32'h00000080, 32'h0, 2'b00); wait_done();
        issue(1, 0, 3'd1, 32'h12, 32'h0, 32'hFFFF80FF, 32'h0, 2'b00); wait_done();
        issue(1, 0, 3'd5, 32'h10, 32'h0, 32'h00007F01, 32'h0, 2'b00); wait_done();
        issue(1, 0, 3'd0, 32'h11, 32'h0, 32'h0000007F, 32'h0, 2'b00); wait_done();

        // Back-to-back: the next request is held while the previous one is in flight.
        issue(0, 1, 3'd0, 32'h21, 32'hAB, 32'h0, 32'h1122AB44, 2'b00);
        issue(0, 1, 3'd1, 32'h22, 32'h5555, 32'h0, 32'h5555AB44, 2'b00);
        issue(1, 0, 3'd2, 32'h20, 32'h0, 32'h5555AB44, 32'h0, 2'b00); wait_done();

        issue(0, 1, 3'd2, 32'hFFFF0004, 32'h5A, 32'h0, 32'h0000005A, 2'b00); wait_done();
        issue(0, 1, 3'd1, 32'hFFFF0006, 32'h1234, 32'h0, 32'h12340000, 2'b00); wait_done();
        issue(0, 1, 3'd0, 32'hFFFF0003, 32'h77, 32'h0, 32'h77000000, 2'b00); wait_done();
        issue(0, 1, 3'd2, 32'h24, 32'h01020304, 32'h0, 32'h01020304, 2'b00); wait_done();

        issue(1, 0, 3'd2, 32'h22, 32'h0, 32'h0, 32'h0, 2'b01); wait_done();
        issue(1, 0, 3'd3, 32'h10, 32'h0, 32'h0, 32'h0, 2'b10); wait_done();
        issue(1, 1, 3'd0, 32'h10, 32'h0, 32'h0, 32'h0, 2'b10); wait_done();
        issue(0, 0, 3'd0, 32'h10, 32'h0, 32'h0, 32'h0, 2'b10); wait_done();
        issue(0, 1, 3'd4, 32'h10, 32'h0, 32'h0, 32'h0, 2'b10); wait_done();
        issue(1, 0, 3'd1, 32'h13, 32'h0, 32'h0, 32'h0, 2'b01); wait_done();
        issue(0, 1, 3'd1, 32'h21, 32'h0, 32'h0, 32'h0, 2'b01); wait_done();
        issue(1, 0, 3'd3, 32'h23, 32'h0, 32'h0, 32'h0, 2'b10); wait_done();

        // Reset lands while an RMW halfword store sits in RMW_CAP; the word must stay intact.
        issue(0, 1, 3'd1, 32'h32, 32'hBEEF, 32'h0, 32'hBEEFF00D, 2'b00);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1, 0, 3'd2, 32'h30, 32'h0, 32'hCAFEF00D, 32'h0, 2'b00); wait_done();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
